// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: sync, polarity normalise, debounce, press/release pulses.
// Optional auto-repeat of press pulses while held, built when BUTTON_CONDITIONER_AUTOREPEAT_EN is defined.
module button_conditioner #(
  parameter int CHANNELS      = 3,
  parameter int STABLE_CYCLES = 50000,
  parameter int COUNT_WIDTH   = 16,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [CHANNELS-1:0] i_button_raw,
  output logic [CHANNELS-1:0] o_level,
  output logic [CHANNELS-1:0] o_pressed,
  output logic [CHANNELS-1:0] o_released
);

  localparam logic                   INACTIVE   = (ACTIVE_LOW != 0);
  localparam logic [COUNT_WIDTH-1:0] STABLE_MAX = COUNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam logic [COUNT_WIDTH-1:0] DELAY_MAX  = COUNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [COUNT_WIDTH-1:0] PERIOD_MAX = COUNT_WIDTH'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rpt_state_t;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_level;
    logic                   r_pressed;
    logic                   r_released;
    logic [COUNT_WIDTH-1:0] r_db_count;
    logic                   w_s;
    logic                   w_toggle;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_repeat;

    assign w_s      = r_sync2 ^ INACTIVE;
    assign w_toggle = (w_s != r_level) && (r_db_count == STABLE_MAX);
    assign w_rise   = w_toggle && !r_level;
    assign w_fall   = w_toggle && r_level;

    // Counter only runs while the synchronised input disagrees with the level.
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_sync1    <= INACTIVE;
        r_sync2    <= INACTIVE;
        r_level    <= 1'b0;
        r_pressed  <= 1'b0;
        r_released <= 1'b0;
        r_db_count <= '0;
      end else begin
        r_sync1    <= i_button_raw[gi];
        r_sync2    <= r_sync1;
        r_pressed  <= w_rise | w_repeat;
        r_released <= w_fall;
        if (w_s == r_level) begin
          r_db_count <= '0;
        end else if (w_toggle) begin
          r_db_count <= '0;
          r_level    <= ~r_level;
        end else begin
          r_db_count <= r_db_count + CNT_ONE;
        end
      end
    end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    rpt_state_t             r_state;
    rpt_state_t             w_state_next;
    logic [COUNT_WIDTH-1:0] r_rpt_count;
    logic [COUNT_WIDTH-1:0] w_rpt_count_next;

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_state     <= ST_IDLE;
        r_rpt_count <= '0;
      end else begin
        r_state     <= w_state_next;
        r_rpt_count <= w_rpt_count_next;
      end
    end

    // A release wins over any pending repeat in the same cycle.
    always_comb begin
      w_state_next     = r_state;
      w_rpt_count_next = r_rpt_count;
      w_repeat         = 1'b0;
      if (w_fall) begin
        w_state_next     = ST_IDLE;
        w_rpt_count_next = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              w_state_next     = ST_DELAY;
              w_rpt_count_next = '0;
            end
          end
          ST_DELAY: begin
            if (r_rpt_count == DELAY_MAX) begin
              w_repeat         = 1'b1;
              w_rpt_count_next = '0;
              w_state_next     = ST_REPEAT;
            end else begin
              w_rpt_count_next = r_rpt_count + CNT_ONE;
            end
          end
          ST_REPEAT: begin
            if (r_rpt_count == PERIOD_MAX) begin
              w_repeat         = 1'b1;
              w_rpt_count_next = '0;
            end else begin
              w_rpt_count_next = r_rpt_count + CNT_ONE;
            end
          end
          default: begin
            w_state_next     = ST_IDLE;
            w_rpt_count_next = '0;
          end
        endcase
      end
    end
`else
    assign w_repeat = 1'b0;
`endif

    assign o_level[gi]    = r_level;
    assign o_pressed[gi]  = r_pressed;
    assign o_released[gi] = r_released;
  end

endmodule
